// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: register sentinel, forwarding select codes and
// the ID/EX control bundle.
package cpu_pkg;

    localparam int         ALU_OP_W = 4;
    localparam logic [4:0] NULL_REG = 5'b11111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                mem_read;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    // All-zero control: an instruction slot that does nothing.
    function automatic ctrl_t bubble_ctrl();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// 3:1 operand forwarding mux; the reserved select code falls back to the
// stored register-file value.
module operand_fwd_mux
    import cpu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    sel,
    input  logic [DW-1:0] reg_data,
    input  logic [DW-1:0] mem_data,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] data
);

    always_comb begin
        data = reg_data;
        case (sel)
            FWD_MEM: data = mem_data;
            FWD_WB:  data = wb_data;
            default: data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// a saturating bubble counter and forwarded ALU operand buses.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int            DW       = 32,
    parameter int            RW       = 5,
    parameter logic [RW-1:0] NULL_REG = cpu_pkg::NULL_REG,
    parameter int            CW       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [RW-1:0]       id_rs,
    input  logic [RW-1:0]       id_rt,
    input  logic                id_uses_rt,
    input  logic [RW-1:0]       id_dest,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_alu_src,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [DW-1:0]       id_rs_data,
    input  logic [DW-1:0]       id_rt_data,
    input  logic [DW-1:0]       id_imm,
    input  logic                hold,
    input  logic                flush,
    input  logic [1:0]          fwd_a,
    input  logic [1:0]          fwd_b,
    input  logic [DW-1:0]       mem_result,
    input  logic [DW-1:0]       wb_data,
    output logic                ex_valid,
    output logic [RW-1:0]       ex_rs,
    output logic [RW-1:0]       ex_rt,
    output logic [RW-1:0]       ex_dest,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [DW-1:0]       ex_rt_fwd,
    output logic [DW-1:0]       op_a,
    output logic [DW-1:0]       op_b,
    output logic                stall_id,
    output logic [CW-1:0]       bubble_cnt
);

    ctrl_t         ctrl_reg;
    ctrl_t         ctrl_next;
    logic [RW-1:0] rs_reg;
    logic [RW-1:0] rt_reg;
    logic [RW-1:0] dest_reg;
    logic [RW-1:0] dest_next;
    logic [DW-1:0] rs_data_reg;
    logic [DW-1:0] rt_data_reg;
    logic [DW-1:0] imm_reg;
    logic [CW-1:0] bubble_cnt_reg;

    logic hazard;
    logic load_bubble;
    logic load_instr;
    logic count_bubble;

    // An empty decode slot enters EX with all side effects suppressed.
    always_comb begin
        ctrl_next = bubble_ctrl();
        dest_next = NULL_REG;
        if (id_valid) begin
            ctrl_next.valid     = 1'b1;
            ctrl_next.reg_write = id_reg_write;
            ctrl_next.mem_read  = id_mem_read;
            ctrl_next.alu_src   = id_alu_src;
            ctrl_next.alu_op    = id_alu_op;
            dest_next           = id_dest;
        end
    end

    assign hazard = ctrl_reg.valid & ctrl_reg.mem_read & (dest_reg != NULL_REG) & id_valid &
                    ((dest_reg == id_rs) | (id_uses_rt & (dest_reg == id_rt)));

    assign stall_id     = hazard & ~flush;
    assign load_bubble  = flush | (~hold & hazard);
    assign load_instr   = ~flush & ~hold & ~hazard;
    assign count_bubble = ~flush & ~hold & hazard & ~(&bubble_cnt_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg    <= bubble_ctrl();
            rs_reg      <= NULL_REG;
            rt_reg      <= NULL_REG;
            dest_reg    <= NULL_REG;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
            imm_reg     <= '0;
        end else if (load_bubble) begin
            // Operand data is left as is; a bubble never consumes it.
            ctrl_reg <= bubble_ctrl();
            rs_reg   <= NULL_REG;
            rt_reg   <= NULL_REG;
            dest_reg <= NULL_REG;
        end else if (load_instr) begin
            ctrl_reg    <= ctrl_next;
            rs_reg      <= id_rs;
            rt_reg      <= id_rt;
            dest_reg    <= dest_next;
            rs_data_reg <= id_rs_data;
            rt_data_reg <= id_rt_data;
            imm_reg     <= id_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_reg <= '0;
        end else if (count_bubble) begin
            bubble_cnt_reg <= bubble_cnt_reg + CW'(1);
        end
    end

    // Index 0 forwards rs, index 1 forwards rt.
    logic [1:0]    fwd_sel    [2];
    logic [DW-1:0] fwd_stored [2];
    logic [DW-1:0] fwd_out    [2];

    assign fwd_sel[0]    = fwd_a;
    assign fwd_sel[1]    = fwd_b;
    assign fwd_stored[0] = rs_data_reg;
    assign fwd_stored[1] = rt_data_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            operand_fwd_mux #(
                .DW(DW)
            ) u_fwd_mux (
                .sel      (fwd_sel[gi]),
                .reg_data (fwd_stored[gi]),
                .mem_data (mem_result),
                .wb_data  (wb_data),
                .data     (fwd_out[gi])
            );
        end
    endgenerate

    assign op_a      = fwd_out[0];
    assign ex_rt_fwd = fwd_out[1];
    assign op_b      = ctrl_reg.alu_src ? imm_reg : fwd_out[1];

    assign ex_valid     = ctrl_reg.valid;
    assign ex_rs        = rs_reg;
    assign ex_rt        = rt_reg;
    assign ex_dest      = dest_reg;
    assign ex_reg_write = ctrl_reg.reg_write;
    assign ex_mem_read  = ctrl_reg.mem_read;
    assign ex_alu_op    = ctrl_reg.alu_op;
    assign bubble_cnt   = bubble_cnt_reg;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the 5-stage core.
- Latches decoded operands and control, and exports the EX-stage source and destination register numbers to the forwarding unit.
- Consumes the forwarding unit's 2-bit select codes to drive the ALU operand buses.
- Detects load-use hazards, inserts one bubble per hazard, and counts inserted bubbles for performance monitoring.

Parameters:
- DW, 32, datapath width
- RW, 5, register-number width
- NULL_REG, 5'b11111, register number meaning "no destination"; never forwarded or hazard-checked
- CW, 16, bubble-counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs  in  RW  decode source 1
- id_rt  in  RW  decode source 2
- id_uses_rt  in  1  instruction reads rt as a register
- id_dest  in  RW  decode destination
- id_reg_write  in  1  instruction writes the register file
- id_mem_read  in  1  instruction is a load
- id_alu_src  in  1  1 = op_b takes the immediate
- id_alu_op  in  4  ALU function
- id_rs_data  in  DW  register-file read data for rs
- id_rt_data  in  DW  register-file read data for rt
- id_imm  in  DW  sign-extended immediate
- hold  in  1  downstream stall; freeze this stage
- flush  in  1  branch/exception squash
- fwd_a  in  2  forwarding select for rs
- fwd_b  in  2  forwarding select for rt
- mem_result  in  DW  ALU result held in EX/MEM
- wb_data  in  DW  write-back data
- ex_valid  out  1  registered
- ex_rs  out  RW  registered; to forwarding unit Reg1
- ex_rt  out  RW  registered; to forwarding unit Reg2
- ex_dest  out  RW  registered
- ex_reg_write  out  1  registered
- ex_mem_read  out  1  registered
- ex_alu_op  out  4  registered
- ex_rt_fwd  out  DW  forwarded rt value, used as store data
- op_a  out  DW  ALU operand A
- op_b  out  DW  ALU operand B
- stall_id  out  1  freeze PC and IF/ID
- bubble_cnt  out  CW  saturating count of inserted bubbles

Behaviour:
- Reset, asynchronous on rst_n low:
  - all ex_* control outputs 0
  - ex_rs, ex_rt and ex_dest set to NULL_REG
  - stored data set to 0
  - bubble_cnt 0
  - a reset mid-operation discards the in-flight instruction
- Load-use hazard term. hazard = ex_valid & ex_mem_read & ex_dest!=NULL_REG & id_valid & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)).
- stall_id is combinational: stall_id = hazard & ~flush. It is high for exactly one cycle per load-use pair, because the bubble clears ex_mem_read.
- Register update on each clk rising edge, in priority order:
  1. flush: load a bubble (valid 0, reg_write 0, mem_read 0, dest NULL_REG, rs/rt NULL_REG). flush overrides hold.
  2. hold: keep all registers unchanged. stall_id is still driven combinationally.
  3. hazard: load a bubble and increment bubble_cnt.
  4. otherwise: load all id_* fields. When id_valid is 0, control fields are forced to 0 and dest to NULL_REG.
- bubble_cnt saturates at all-ones; it does not wrap. A flush-generated bubble is not counted.
- Operand muxing is combinational from the registered data plus the fwd inputs, so there are zero cycles of added latency.
  - fwd 2'b00: use the stored register data.
  - fwd 2'b10: use mem_result.
  - fwd 2'b01: use wb_data.
  - fwd 2'b11: reserved; use the stored data.
  - op_a = forwarded rs.
  - ex_rt_fwd = forwarded rt.
  - op_b = id_imm stored when alu_src is 1, else ex_rt_fwd.
- Instruction latency: decode to EX outputs is 1 cycle.
- A hazard concurrent with hold: stall_id stays asserted while hold is high. No bubble is loaded until hold drops; then one bubble is loaded.

Decomposition:
- Shared package cpu_pkg holds:
  - NULL_REG
  - the forwarding select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - the ALU op width
  - a bubble/control-bundle struct type
- One natural sub-module: operand_fwd_mux, the 3:1 forwarding mux. It is instantiated twice, for rs and rt.

Test Plan:
1. Reset and passthrough. Hold rst_n low for 2 cycles: outputs 0, ex_rs/rt/dest = 31, bubble_cnt 0. Release, present id_rs=3, id_rt=4, data 0x11/0x22, fwd 00: next cycle op_a=0x11, op_b=0x22, ex_rs=3, ex_rt=4.
2. Forwarding. Stored rs data 0x11, mem_result=0xAAAA, wb_data=0xBBBB:
   - fwd_a=10 → op_a=0xAAAA
   - fwd_a=01 → op_a=0xBBBB
   - fwd_a=11 → op_a=0x11
   - alu_src=1, imm=0x5 → op_b=0x5 regardless of fwd_b
3. Load-use. Load into $8 is in EX; decode presents id_rs=8. Required: stall_id=1 for one cycle, next ex_valid=0, bubble_cnt=1, then the dependent instruction enters EX. Repeat with dest=31: no stall. Repeat with id_rt=8 and id_uses_rt=0: no stall.
4. Flush priority. flush together with hold and a hazard: next cycle bubble, stall_id=0, bubble_cnt unchanged.
5. Hold. Assert hold for 3 cycles with changing id_*: ex_* stay frozen. A pending hazard keeps stall_id=1 throughout, and exactly one bubble is counted after release.
6. Saturation and async reset. Force 2^16+3 hazards: bubble_cnt=0xFFFF. Drop rst_n between clock edges: outputs clear immediately, without waiting for clk.
